ifid_queue: RTL and testbench
=============================

Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry instruction queue between the PC unit/IM (fetch) and Ctrl/rf/Extender (decode).
- Uses a valid/ready handshake, so fetch can keep running while decode stalls.
- Flush empties the whole queue in one cycle.
- The head entry is split combinationally into decode fields (op, rs, rt, rd, shamt, funct, imm16, jump index).

Parameters:
- INSTR_W, 32, instruction word width; must be ≥32, only bits [31:0] are decoded.
- PC_W, 32, width of each PC tag (PC, jalPC, jrPC).
- DEPTH, 2, number of queue entries; power of 2, ≥2.

Ports:
- Clk  in  1  clock, rising edge.
- ReSet_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- OpCode  in  INSTR_W  instruction from IM.
- PC  in  PC_W  fetch PC.
- jalPC  in  PC_W  link PC.
- jrPC  in  PC_W  register-jump PC.
- IF_Flush  in  1  discard all entries, including a same-cycle push.
- out_valid  out  1  head entry present; equals (count != 0).
- out_ready  in  1  decode consumes the head this cycle (low = stall).
- PC_IDIF  out  PC_W  head PC.
- jalPC_IDIF  out  PC_W  head jalPC.
- jrPC_IDIF  out  PC_W  head jrPC.
- op  out  6  head instr[31:26].
- rfReSel1  out  5  head instr[25:21].
- rfReSel2  out  5  head instr[20:16].
- rfReSel3  out  5  head instr[15:11].
- shamt  out  5  head instr[10:6].
- funct  out  6  head instr[5:0].
- extDataIn  out  16  head instr[15:0].
- jumpstr  out  26  head instr[25:0].
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, ReSet_n=0):
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, in_ready=1.
  - All storage cleared to 0.
  - Release is synchronous to the next Clk edge.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Push, pop, count update and flush all take effect on the rising Clk edge.
- Ordering is FIFO. Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
- count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on push & pop: write at wr_ptr, read advances, both pointers increment.
- Full (count==DEPTH):
  - in_ready=0, so push is impossible even if pop is asserted the same cycle.
  - No full-queue pass-through.
- Empty (count==0):
  - out_valid=0.
  - All decode outputs and *_IDIF forced to 0, i.e. NOP (sll $0,$0,0).
  - The empty case never writes through to decode: a pushed entry is visible at the outputs starting the cycle after its push edge (1-cycle latency).
- Decode outputs are combinational from the head entry's storage and stable while out_ready=0 (stall hold).
- IF_Flush=1 at an edge:
  - rd_ptr=wr_ptr=0, count=0.
  - Any concurrent push and pop are ignored; flush has priority.
  - Storage contents need not be cleared; outputs read as 0 because the queue is empty.
- Flush with an empty queue is harmless.
- in_valid while in_ready=0: the entry is not captured; fetch must hold it.
- ReSet_n asserted mid-operation: immediate return to the reset state regardless of Clk.
- Zero-width or X inputs are never written when push=0; storage writes are gated by push.

Optional Feature:
- Macro IFID_QUEUE_PCERR_EN, when defined:
  - Adds output pc_err (1 bit) and a per-entry err bit, captured as (PC[1:0]!=0) on push.
  - When the head err=1: op, funct, rfReSel1/2/3, shamt, extDataIn and jumpstr are forced to 0 (NOP); pc_err=1; PC_IDIF still carries the faulting PC.
  - pc_err=0 when empty or after reset/flush.
- When not defined: no pc_err port, no err storage; misaligned PCs pass through unchecked.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0, op=0, PC_IDIF=0.
- Push OpCode=32'h012A4020 with PC=32'h3000, out_ready=1 → next cycle out_valid=1, op=0, rfReSel1=9, rfReSel2=10, rfReSel3=8, funct=6'h20, PC_IDIF=32'h3000; following cycle empty.
- out_ready=0, push PC 3000, 3004, 3008 (DEPTH=2) → count=2, in_ready=0 after second push, third held; PC_IDIF stays 3000. Then out_ready=1 → drains 3000, 3004, 3008 in order.
- Full queue, in_valid=1, out_ready=1 same edge → pop only, count 2→1, then push next cycle; pointers wrap cleanly over ≥5 entries.
- count=2 plus IF_Flush=1 with a concurrent push of PC 3010 → next cycle count=0, out_valid=0, all decode outputs 0; 3010 never appears.
- With IFID_QUEUE_PCERR_EN: push PC=32'h3002, OpCode=32'h8C880004 → pc_err=1, op=0, extDataIn=0, PC_IDIF=32'h3002. Without the macro: op=6'h23, extDataIn=16'h0004.

Source files
------------

// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - DEPTH-entry IF/ID instruction queue with valid/ready handshake and head decode.
// Optional misaligned-PC flagging enabled by defining IFID_QUEUE_PCERR_EN.
module ifid_queue #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 2
) (
    input  logic                         Clk,
    input  logic                         ReSet_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_W-1:0]           OpCode,
    input  logic [PC_W-1:0]              PC,
    input  logic [PC_W-1:0]              jalPC,
    input  logic [PC_W-1:0]              jrPC,
    input  logic                         IF_Flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              PC_IDIF,
    output logic [PC_W-1:0]              jalPC_IDIF,
    output logic [PC_W-1:0]              jrPC_IDIF,
    output logic [5:0]                   op,
    output logic [4:0]                   rfReSel1,
    output logic [4:0]                   rfReSel2,
    output logic [4:0]                   rfReSel3,
    output logic [4:0]                   shamt,
    output logic [5:0]                   funct,
    output logic [15:0]                  extDataIn,
    output logic [25:0]                  jumpstr,
`ifdef IFID_QUEUE_PCERR_EN
    output logic                         pc_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PC_W-1:0]    r_pc    [DEPTH];
    logic [PC_W-1:0]    r_jal   [DEPTH];
    logic [PC_W-1:0]    r_jr    [DEPTH];
`ifdef IFID_QUEUE_PCERR_EN
    logic [DEPTH-1:0]   r_err;
`endif

    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_kill;
    logic [31:0]        w_head_instr;
    logic [31:0]        w_dec;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
                r_jal[i]   <= '0;
                r_jr[i]    <= '0;
            end
`ifdef IFID_QUEUE_PCERR_EN
            r_err <= '0;
`endif
        end else if (IF_Flush) begin
            // Flush wins over any same-edge push or pop; stale storage is masked by count==0.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= OpCode;
                r_pc[r_wr_ptr]    <= PC;
                r_jal[r_wr_ptr]   <= jalPC;
                r_jr[r_wr_ptr]    <= jrPC;
`ifdef IFID_QUEUE_PCERR_EN
                r_err[r_wr_ptr]   <= (PC[1:0] != 2'b00);
`endif
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_instr = r_instr[r_rd_ptr][31:0];

`ifdef IFID_QUEUE_PCERR_EN
    assign pc_err = out_valid & r_err[r_rd_ptr];
    assign w_kill = ~out_valid | r_err[r_rd_ptr];
`else
    assign w_kill = ~out_valid;
`endif

    // An empty (or faulting) head decodes as NOP: sll $0,$0,0 is all-zero.
    assign w_dec = w_kill ? 32'd0 : w_head_instr;

    assign op        = w_dec[31:26];
    assign rfReSel1  = w_dec[25:21];
    assign rfReSel2  = w_dec[20:16];
    assign rfReSel3  = w_dec[15:11];
    assign shamt     = w_dec[10:6];
    assign funct     = w_dec[5:0];
    assign extDataIn = w_dec[15:0];
    assign jumpstr   = w_dec[25:0];

    assign PC_IDIF    = out_valid ? r_pc[r_rd_ptr]  : '0;
    assign jalPC_IDIF = out_valid ? r_jal[r_rd_ptr] : '0;
    assign jrPC_IDIF  = out_valid ? r_jr[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_ifid_queue.sv
// tb/tb_ifid_queue.sv - directed self-checking bench for ifid_queue (DEPTH=2).
module tb_ifid_queue;

    logic        Clk = 1'b0;
    logic        ReSet_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] OpCode;
    logic [31:0] PC;
    logic [31:0] jalPC;
    logic [31:0] jrPC;
    logic        IF_Flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] PC_IDIF;
    logic [31:0] jalPC_IDIF;
    logic [31:0] jrPC_IDIF;
    logic [5:0]  op;
    logic [4:0]  rfReSel1;
    logic [4:0]  rfReSel2;
    logic [4:0]  rfReSel3;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] extDataIn;
    logic [25:0] jumpstr;
`ifdef IFID_QUEUE_PCERR_EN
    logic        pc_err;
`endif
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    ifid_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(2)) dut (
        .Clk        (Clk),
        .ReSet_n    (ReSet_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .OpCode     (OpCode),
        .PC         (PC),
        .jalPC      (jalPC),
        .jrPC       (jrPC),
        .IF_Flush   (IF_Flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .PC_IDIF    (PC_IDIF),
        .jalPC_IDIF (jalPC_IDIF),
        .jrPC_IDIF  (jrPC_IDIF),
        .op         (op),
        .rfReSel1   (rfReSel1),
        .rfReSel2   (rfReSel2),
        .rfReSel3   (rfReSel3),
        .shamt      (shamt),
        .funct      (funct),
        .extDataIn  (extDataIn),
        .jumpstr    (jumpstr),
`ifdef IFID_QUEUE_PCERR_EN
        .pc_err     (pc_err),
`endif
        .count      (count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Entry driven with OpCode tagged by the PC so the head can be identified from decode too.
    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        PC       = pc;
        jalPC    = pc + 32'd8;
        jrPC     = pc ^ 32'h0000_F000;
        OpCode   = {6'h23, 10'h000, pc[15:0]};
    endtask

    initial begin
        ReSet_n   = 1'b0;
        IF_Flush  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        tick();
        ReSet_n = 1'b1;
        tick();

        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_op", op, 0);
        check("rst_pc", PC_IDIF, 0);

        // Single R-type push: add $8,$9,$10
        out_ready = 1'b1;
        drive(1'b1, 32'h3000);
        OpCode = 32'h012A4020;
        tick();
        drive(1'b0, 32'h0);
        check("r_out_valid", out_valid, 1);
        check("r_op", op, 0);
        check("r_rs", rfReSel1, 9);
        check("r_rt", rfReSel2, 10);
        check("r_rd", rfReSel3, 8);
        check("r_shamt", shamt, 0);
        check("r_funct", funct, 6'h20);
        check("r_imm", extDataIn, 16'h4020);
        check("r_jidx", jumpstr, 26'h12A4020);
        check("r_pc", PC_IDIF, 32'h3000);
        check("r_jal", jalPC_IDIF, 32'h3008);
        check("r_jr", jrPC_IDIF, 32'h0000_C000);
        tick();
        check("r_drained_valid", out_valid, 0);
        check("r_drained_rs", rfReSel1, 0);
        check("r_drained_pc", PC_IDIF, 0);

        // Stall: fill to full, third entry held by fetch
        out_ready = 1'b0;
        drive(1'b1, 32'h3000);
        tick();
        check("st1_count", count, 1);
        check("st1_in_ready", in_ready, 1);
        drive(1'b1, 32'h3004);
        tick();
        check("st2_count", count, 2);
        check("st2_in_ready", in_ready, 0);
        drive(1'b1, 32'h3008);
        tick();
        check("st3_count", count, 2);
        check("st3_pc_hold", PC_IDIF, 32'h3000);
        check("st3_imm_hold", extDataIn, 16'h3000);
        // Full with in_valid and out_ready: pop only
        out_ready = 1'b1;
        tick();
        check("fp_count", count, 1);
        check("fp_pc", PC_IDIF, 32'h3004);
        tick();
        check("fp2_count", count, 1);
        check("fp2_pc", PC_IDIF, 32'h3008);
        drive(1'b0, 32'h0);
        tick();
        check("fp3_count", count, 0);

        // Streaming through wrapped pointers
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h3100 + 32'(4 * k));
            tick();
            check("wrap_count", count, 1);
            check("wrap_pc", PC_IDIF, 32'h3100 + 32'(4 * k));
        end
        drive(1'b0, 32'h0);
        tick();
        check("wrap_end_count", count, 0);

        // Flush at count=2 with concurrent push attempt
        out_ready = 1'b0;
        drive(1'b1, 32'h3200);
        tick();
        drive(1'b1, 32'h3204);
        tick();
        check("fl2_pre_count", count, 2);
        drive(1'b1, 32'h3010);
        IF_Flush = 1'b1;
        tick();
        IF_Flush = 1'b0;
        drive(1'b0, 32'h0);
        check("fl2_count", count, 0);
        check("fl2_valid", out_valid, 0);
        check("fl2_op", op, 0);
        check("fl2_imm", extDataIn, 0);
        check("fl2_pc", PC_IDIF, 0);

        // Flush at count=1 where a push is genuinely possible
        drive(1'b1, 32'h3300);
        tick();
        drive(1'b1, 32'h3010);
        IF_Flush  = 1'b1;
        out_ready = 1'b1;
        tick();
        IF_Flush = 1'b0;
        drive(1'b0, 32'h0);
        check("fl1_count", count, 0);
        check("fl1_pc", PC_IDIF, 0);
        tick();
        check("fl1_later_count", count, 0);

        // Flush on empty, then queue resumes from slot 0
        IF_Flush = 1'b1;
        tick();
        IF_Flush = 1'b0;
        check("fle_count", count, 0);
        check("fle_in_ready", in_ready, 1);
        out_ready = 1'b0;
        drive(1'b1, 32'h3020);
        tick();
        drive(1'b0, 32'h0);
        check("post_fl_pc", PC_IDIF, 32'h3020);

        // Asynchronous reset away from the clock edge
        #2;
        ReSet_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", out_valid, 0);
        check("arst_pc", PC_IDIF, 0);
        tick();
        ReSet_n = 1'b1;
        tick();

        // Misaligned PC: lw $8,4($4)
        out_ready = 1'b0;
        drive(1'b1, 32'h3002);
        OpCode = 32'h8C880004;
        tick();
        drive(1'b0, 32'h0);
        check("mis_pc", PC_IDIF, 32'h3002);
`ifdef IFID_QUEUE_PCERR_EN
        check("mis_pc_err", pc_err, 1);
        check("mis_op", op, 0);
        check("mis_imm", extDataIn, 0);
        check("mis_rs", rfReSel1, 0);
`else
        check("mis_op", op, 6'h23);
        check("mis_imm", extDataIn, 16'h0004);
        check("mis_rs", rfReSel1, 4);
        check("mis_rt", rfReSel2, 8);
`endif
        IF_Flush = 1'b1;
        tick();
        IF_Flush = 1'b0;
`ifdef IFID_QUEUE_PCERR_EN
        check("mis_fl_pc_err", pc_err, 0);
`endif
        check("mis_fl_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
